// File: rtl/bp_pht_update_ctrl.sv
// PHT write-port sequencer: post-reset sweep to weakly-not-taken, then a queued
// read-modify-write of one 2-bit counter per resolved branch. Also owns the gshare GHR.
module bp_pht_update_ctrl #(
    parameter int IDX_W      = 11,
    parameter int SLOT_W     = 3,
    parameter int GHR_W      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      upd_valid,
    output logic                      upd_ready,
    input  logic [31:0]               upd_pc,
    input  logic                      upd_taken,
    output logic [GHR_W-1:0]          ghr,
    output logic                      init_done,
    output logic                      busy,
    output logic                      sram_web,
    output logic [IDX_W-SLOT_W-1:0]   sram_addr,
    output logic [(1<<SLOT_W)-1:0]    sram_wmask,
    output logic [(2<<SLOT_W)-1:0]    sram_din,
    input  logic [(2<<SLOT_W)-1:0]    sram_dout
);
    localparam int WA_W  = IDX_W - SLOT_W;
    localparam int SLOTS = 1 << SLOT_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {INIT, IDLE, WRITE} state_t;
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } upd_t;

    state_t             state, state_nxt;
    logic [WA_W-1:0]    sweep_cnt;
    logic [GHR_W-1:0]   ghr_q;
    upd_t               fifo [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr, rd_ptr;
    logic [WA_W-1:0]    rmw_addr;
    logic [SLOT_W-1:0]  rmw_slot;
    logic               rmw_taken;
    logic               empty, full, push, pop;
    upd_t               head;
    logic [IDX_W-1:0]   idx_in;
    logic [1:0]         cur_ctr, nxt_ctr;
    logic               unused_pc;

    assign unused_pc = ^{upd_pc[31:IDX_W+2], upd_pc[1:0]};

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = ((wr_ptr - rd_ptr) == (PTR_W+1)'(FIFO_DEPTH));
    assign push   = upd_valid && !full;
    assign pop    = (state == WRITE);
    assign head   = fifo[rd_ptr[PTR_W-1:0]];
    // Index hashes with the history as it stood before this branch is shifted in.
    assign idx_in = upd_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);

    assign upd_ready = !full;
    assign ghr       = rst ? '0 : ghr_q;
    assign init_done = !rst && (state != INIT);
    assign busy      = rst || (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            sweep_cnt <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ghr_q     <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT && sweep_cnt != '1)
                sweep_cnt <= sweep_cnt + WA_W'(1);
            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
                ghr_q  <= GHR_W'({ghr_q, upd_taken});
            end
            if (pop)
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr[PTR_W-1:0]] <= {idx_in, upd_taken};
        if (state == IDLE && !empty) begin
            rmw_addr  <= head.idx[IDX_W-1:SLOT_W];
            rmw_slot  <= head.idx[SLOT_W-1:0];
            rmw_taken <= head.taken;
        end
    end

    always_comb begin
        state_nxt  = state;
        sram_web   = 1'b1;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_din   = '0;
        cur_ctr    = sram_dout[{rmw_slot, 1'b0} +: 2];
        if (rmw_taken)
            nxt_ctr = (cur_ctr == 2'b11) ? cur_ctr : cur_ctr + 2'b01;
        else
            nxt_ctr = (cur_ctr == 2'b00) ? cur_ctr : cur_ctr - 2'b01;
        case (state)
            INIT: begin
                sram_web   = 1'b0;
                sram_wmask = '1;
                sram_din   = {SLOTS{2'b01}};
                sram_addr  = sweep_cnt;
                if (sweep_cnt == '1)
                    state_nxt = IDLE;
            end
            IDLE: begin
                if (!empty) begin
                    sram_addr = head.idx[IDX_W-1:SLOT_W];
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                sram_web   = 1'b0;
                sram_addr  = rmw_addr;
                sram_wmask = SLOTS'(1) << rmw_slot;
                sram_din   = sram_dout;
                sram_din[{rmw_slot, 1'b0} +: 2] = nxt_ctr;
                state_nxt  = IDLE;
            end
            default: state_nxt = INIT;
        endcase
        // Reset masks everything, including a write already in progress.
        if (rst) begin
            sram_web   = 1'b1;
            sram_addr  = '0;
            sram_wmask = '0;
            sram_din   = '0;
        end
    end
endmodule
